// File: rtl/race_pkg.sv
// Shared race definitions: state encoding, HUD-facing widths, frame counter sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Used by race_ctl and by the HUD digit ROMs, which decode countdown and lap_count
// with the same CNT_W / LAP_W widths.
package race_pkg;

    // Width of the lap counter and of the countdown digit as seen by the HUD.
    localparam int LAP_W   = 4;
    localparam int CNT_W   = 3;

    // Race sequencer state encoding. Kept as plain constants so legacy
    // decoders that compare raw state codes keep working.
    localparam int STATE_W = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_RACING    = 3'd2;
    localparam logic [2:0] ST_FINISHED  = 3'd3;
    localparam logic [2:0] ST_TIMEOUT   = 3'd4;

    // Frame counter width: enough bits to count 0 .. max(a,b)-1, never zero wide.
    function automatic int fcnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: vblnk rising-edge detector plus a wrapping frame counter with terminal-count flag.
// Latency: tick_o is high 1 cycle after the vblnk rise; counter advances on the edge after that.
// Backpressure: none; vblnk is sampled every cycle and every rising edge yields exactly one tick.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   vblnk_i        vertical blanking level from the video timing generator
//   clr_i          holds the counter at zero (wins over en_i)
//   en_i           counter advances on each tick while high
//   tc_val_i       terminal count; the counter wraps to zero on a tick at this value
//   tick_o         registered one-cycle frame tick
//   tc_o           counter currently equals tc_val_i (a tick now completes the period)
module frame_tick_gen #(
    parameter int FCNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vblnk_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [FCNT_W-1:0] tc_val_i,
    output logic              tick_o,
    output logic              tc_o
);

    logic              vblnk_q;
    logic              tick_q;
    logic              tick_d;
    logic [FCNT_W-1:0] cnt_q;
    logic [FCNT_W-1:0] cnt_d;

    // Only the 0->1 transition counts, so a long blanking interval is one frame.
    assign tick_d = vblnk_i & ~vblnk_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && tick_q) begin
            cnt_d = (cnt_q == tc_val_i) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vblnk_q <= 1'b0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vblnk_q <= vblnk_i;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tick_o = tick_q;
    assign tc_o   = (cnt_q == tc_val_i);

endmodule

// File: rtl/race_ctl.sv
// Race sequencer: 3-2-1 countdown, gated racing with lap counting, finish/timeout result hold, race_done.
// Latency: registered outputs, 1 cycle from inputs; 2 cycles from a vblnk rise (frame tick path).
// Backpressure: none; all inputs are levels or single-cycle pulses consumed on arrival.
//
// Ports:
//   pclk, rst          pixel clock, asynchronous active-high reset
//   track_visible      rising edge starts a race from IDLE; low aborts any running race
//   vblnk              frame timing; each rising edge is one frame tick
//   lap_finished       1-cycle lap pulse; counted only with checkpoints_ok high
//   checkpoints_ok     all checkpoints passed for the lap in progress
//   max_time_exceeded  lap timer overflow; ends the race as a timeout
//   countdown          countdown digit, 0 outside COUNTDOWN
//   controls_en        enables car key input while racing
//   timer_start        1-cycle lap timer start pulse
//   timer_stop         lap timer freeze level during the result hold
//   lap_count          valid laps of the current/last race
//   timed_out          last race ended by timeout
//   race_done          1-cycle pulse after the result hold
module race_ctl
    import race_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 60,
    parameter int COUNT_STEPS     = 3,
    parameter int LAP_TARGET      = 3,
    parameter int HOLD_FRAMES     = 180
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             track_visible,
    input  logic             vblnk,
    input  logic             lap_finished,
    input  logic             checkpoints_ok,
    input  logic             max_time_exceeded,
    output logic [CNT_W-1:0] countdown,
    output logic             controls_en,
    output logic             timer_start,
    output logic             timer_stop,
    output logic [LAP_W-1:0] lap_count,
    output logic             timed_out,
    output logic             race_done
);

    localparam int FCNT_W = fcnt_width(FRAMES_PER_STEP, HOLD_FRAMES);
    localparam logic [FCNT_W-1:0] STEP_TC  = FCNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [FCNT_W-1:0] HOLD_TC  = FCNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(COUNT_STEPS);
    localparam logic [LAP_W-1:0]  LAP_MAX  = LAP_W'(LAP_TARGET);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cd_q, cd_d;
    logic               ce_q, ce_d;
    logic               tstart_q, tstart_d;
    logic               tstop_q, tstop_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic               to_q, to_d;
    logic               done_q, done_d;
    logic               tv_q;

    logic               tv_rise;
    logic               abort;
    logic               valid_lap;
    logic               frame_tick;
    logic               frame_tc;
    logic               period_end;
    logic               fcnt_clr;
    logic [FCNT_W-1:0]  fcnt_tc_val;

    assign tv_rise   = track_visible & ~tv_q;
    assign abort     = (state_q != ST_IDLE) && !track_visible;
    assign valid_lap = lap_finished & checkpoints_ok;

    // The frame counter only runs while a timed phase is active: countdown
    // steps and the result hold. Holding it at zero in IDLE and RACING means
    // every timed phase starts from a clean count without an explicit load.
    assign fcnt_clr    = (state_q == ST_IDLE) || (state_q == ST_RACING);
    assign fcnt_tc_val = (state_q == ST_COUNTDOWN) ? STEP_TC : HOLD_TC;
    assign period_end  = frame_tick & frame_tc;

    frame_tick_gen #(
        .FCNT_W   (FCNT_W)
    ) u_frame_tick (
        .clk_i    (pclk),
        .rst_i    (rst),
        .vblnk_i  (vblnk),
        .clr_i    (fcnt_clr),
        .en_i     (~fcnt_clr),
        .tc_val_i (fcnt_tc_val),
        .tick_o   (frame_tick),
        .tc_o     (frame_tc)
    );

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        ce_d     = ce_q;
        tstart_d = 1'b0;
        tstop_d  = tstop_q;
        lap_d    = lap_q;
        to_d     = to_q;
        done_d   = 1'b0;

        if (abort) begin
            // Leaving the track overrides every other event; lap_count and
            // timed_out are left as they were for the HUD.
            state_d = ST_IDLE;
            cd_d    = '0;
            ce_d    = 1'b0;
            tstop_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tv_rise) begin
                        state_d = ST_COUNTDOWN;
                        cd_d    = CNT_INIT;
                        lap_d   = '0;
                        to_d    = 1'b0;
                    end
                end

                ST_COUNTDOWN: begin
                    if (period_end) begin
                        cd_d = cd_q - 1'b1;
                        if (cd_q == CNT_W'(1)) begin
                            state_d  = ST_RACING;
                            tstart_d = 1'b1;
                        end
                    end
                end

                ST_RACING: begin
                    // Controls come up one cycle after timer_start, i.e. on
                    // the first edge seen while already in RACING.
                    ce_d = 1'b1;
                    if (max_time_exceeded) begin
                        // Timeout beats a lap completing in the same cycle.
                        state_d = ST_TIMEOUT;
                        to_d    = 1'b1;
                        ce_d    = 1'b0;
                        tstop_d = 1'b1;
                    end else if (valid_lap) begin
                        if (lap_q < LAP_MAX) begin
                            lap_d = lap_q + 1'b1;
                        end
                        if (lap_q >= LAP_MAX - LAP_W'(1)) begin
                            state_d = ST_FINISHED;
                            ce_d    = 1'b0;
                            tstop_d = 1'b1;
                        end
                    end
                end

                ST_FINISHED, ST_TIMEOUT: begin
                    if (period_end) begin
                        state_d = ST_IDLE;
                        tstop_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cd_d    = '0;
                    ce_d    = 1'b0;
                    tstop_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cd_q     <= '0;
            ce_q     <= 1'b0;
            tstart_q <= 1'b0;
            tstop_q  <= 1'b0;
            lap_q    <= '0;
            to_q     <= 1'b0;
            done_q   <= 1'b0;
            tv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            ce_q     <= ce_d;
            tstart_q <= tstart_d;
            tstop_q  <= tstop_d;
            lap_q    <= lap_d;
            to_q     <= to_d;
            done_q   <= done_d;
            tv_q     <= track_visible;
        end
    end

    assign countdown   = cd_q;
    assign controls_en = ce_q;
    assign timer_start = tstart_q;
    assign timer_stop  = tstop_q;
    assign lap_count   = lap_q;
    assign timed_out   = to_q;
    assign race_done   = done_q;

endmodule

// File: tb/tb_race_ctl.sv
// Self-checking bench for race_ctl with randomized frame timing and lap traffic.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_race_ctl;

    localparam int FPS = 2;
    localparam int CS  = 3;
    localparam int LT  = 2;
    localparam int HF  = 3;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       track_visible = 1'b0;
    logic       vblnk = 1'b0;
    logic       lap_finished = 1'b0;
    logic       checkpoints_ok = 1'b0;
    logic       max_time_exceeded = 1'b0;
    logic [2:0] countdown;
    logic       controls_en;
    logic       timer_start;
    logic       timer_stop;
    logic [3:0] lap_count;
    logic       timed_out;
    logic       race_done;

    int n_tests = 0;
    int n_fail  = 0;

    race_ctl #(
        .FRAMES_PER_STEP (FPS),
        .COUNT_STEPS     (CS),
        .LAP_TARGET      (LT),
        .HOLD_FRAMES     (HF)
    ) dut (
        .pclk              (pclk),
        .rst               (rst),
        .track_visible     (track_visible),
        .vblnk             (vblnk),
        .lap_finished      (lap_finished),
        .checkpoints_ok    (checkpoints_ok),
        .max_time_exceeded (max_time_exceeded),
        .countdown         (countdown),
        .controls_en       (controls_en),
        .timer_start       (timer_start),
        .timer_stop        (timer_stop),
        .lap_count         (lap_count),
        .timed_out         (timed_out),
        .race_done         (race_done)
    );

    always #5 pclk = ~pclk;

    // Pulse bookkeeping, sampled mid-cycle.
    int   cyc = 0;
    int   ts_cnt = 0;
    int   rd_cnt = 0;
    int   ts_cyc = -100;
    int   ce_rise_cyc = -50;
    logic ce_prev = 1'b0;

    always @(negedge pclk) begin
        cyc     <= cyc + 1;
        ce_prev <= controls_en;
        if (timer_start) begin
            ts_cnt <= ts_cnt + 1;
            ts_cyc <= cyc;
        end
        if (race_done) rd_cnt <= rd_cnt + 1;
        if (controls_en && !ce_prev) ce_rise_cyc <= cyc;
    end

    // Reference model state: valid laps credited and result flag of the race.
    int laps;
    bit exp_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One frame: vblnk high for hi cycles then low for lo cycles (lo >= 2 so
    // that the tick and everything it triggers has settled on return).
    task automatic frame(input int hi, input int lo);
        vblnk = 1'b1;
        step(hi);
        vblnk = 1'b0;
        step(lo);
    endtask

    task automatic rand_frame();
        int hi;
        hi = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 20) : $urandom_range(1, 3);
        frame(hi, $urandom_range(2, 4));
    endtask

    task automatic lap_pulse(input bit ok, input bit tmo);
        lap_finished      = 1'b1;
        checkpoints_ok    = ok;
        max_time_exceeded = tmo;
        step(1);
        lap_finished      = 1'b0;
        checkpoints_ok    = 1'b0;
        max_time_exceeded = 1'b0;
    endtask

    task automatic start_race();
        track_visible = 1'b0;
        step(2);
        track_visible = 1'b1;
        step(1);
        laps   = 0;
        exp_to = 1'b0;
        chk("start_countdown", countdown, CS);
        chk("start_lap_count", lap_count, 0);
        chk("start_timed_out", timed_out, 0);
    endtask

    // Runs the countdown; returns 1 if it was aborted at digit 2.
    task automatic run_countdown(input bit do_abort, output bit aborted);
        int ts0;
        int rd0;
        int e;
        ts0 = ts_cnt;
        rd0 = rd_cnt;
        aborted = 1'b0;
        for (int k = 1; k <= FPS * CS; k++) begin
            if (k == 1) frame(15, 2);
            else rand_frame();
            e = (k == FPS * CS) ? 0 : CS - k / FPS;
            chk("countdown", countdown, e);
            if (k < FPS * CS) chk("countdown_ctl_off", controls_en, 0);
            if (do_abort && k == FPS) begin
                track_visible = 1'b0;
                step(1);
                chk("abort_cd_countdown", countdown, 0);
                for (int j = 0; j < 3; j++) rand_frame();
                chk("abort_cd_countdown_stays", countdown, 0);
                chk("abort_cd_no_start", ts_cnt, ts0);
                chk("abort_cd_no_done", rd_cnt, rd0);
                chk("abort_cd_ctl", controls_en, 0);
                aborted = 1'b1;
                return;
            end
        end
        step(1);
        chk("timer_start_pulses", ts_cnt, ts0 + 1);
        chk("controls_en_on", controls_en, 1);
        chk("controls_after_start", ce_rise_cyc - ts_cyc, 1);
        chk("racing_timer_stop", timer_stop, 0);
    endtask

    // kind: 0 finish, 1 timeout, 3 abort while racing
    task automatic run_racing(input int kind);
        bit ok;
        int rd0;
        if (kind == 0) begin
            lap_pulse(1'b0, 1'b0);
            chk("bad_lap_ignored", lap_count, 0);
            for (int i = 0; i < 20 && laps < LT; i++) begin
                if ($urandom_range(0, 2) == 0) rand_frame();
                ok = (i >= 10) ? 1'b1 : 1'(($urandom_range(0, 1)));
                lap_pulse(ok, 1'b0);
                if (ok) laps++;
                chk("lap_count", lap_count, laps);
            end
            chk("finish_timer_stop", timer_stop, 1);
            chk("finish_ctl_off", controls_en, 0);
        end else begin
            for (int i = $urandom_range(0, 4); i > 0; i--) begin
                if ($urandom_range(0, 2) == 0) rand_frame();
                ok = (laps < LT - 1) ? 1'(($urandom_range(0, 1))) : 1'b0;
                lap_pulse(ok, 1'b0);
                if (ok) laps++;
                chk("lap_count_pre", lap_count, laps);
                chk("racing_ctl_on", controls_en, 1);
            end
            if (kind == 1) begin
                lap_pulse(1'b1, 1'b1);
                exp_to = 1'b1;
                chk("timeout_flag", timed_out, 1);
                chk("timeout_lap_kept", lap_count, laps);
                chk("timeout_timer_stop", timer_stop, 1);
                chk("timeout_ctl_off", controls_en, 0);
            end else begin
                rd0 = rd_cnt;
                track_visible = 1'b0;
                lap_pulse(1'b1, 1'(($urandom_range(0, 1))));
                chk("abort_race_ctl", controls_en, 0);
                chk("abort_race_stop", timer_stop, 0);
                chk("abort_race_laps", lap_count, laps);
                chk("abort_race_to", timed_out, 0);
                for (int j = 0; j < HF + 1; j++) rand_frame();
                chk("abort_race_no_done", rd_cnt, rd0);
                return;
            end
        end
        // Result hold
        rd0 = rd_cnt;
        for (int k = 1; k <= HF; k++) begin
            rand_frame();
            if (k < HF) begin
                chk("hold_no_done", rd_cnt, rd0);
                chk("hold_timer_stop", timer_stop, 1);
            end
        end
        chk("race_done_pulse", rd_cnt, rd0 + 1);
        chk("done_timer_stop_off", timer_stop, 0);
        chk("done_laps_held", lap_count, laps);
        chk("done_timed_out_held", timed_out, exp_to);
        // track_visible still high: no new race without a fresh rising edge
        rand_frame();
        rand_frame();
        chk("idle_no_restart", countdown, 0);
        chk("idle_ctl_off", controls_en, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        int kind;
        int ts0;
        #12;
        chk("reset_outputs", {countdown, controls_en, timer_start, timer_stop,
                              lap_count, timed_out, race_done}, 0);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        step(2);

        // Reset in the middle of a race, asserted between clock edges.
        start_race();
        run_countdown(1'b0, ab);
        lap_pulse(1'b1, 1'b0);
        chk("pre_reset_lap", lap_count, 1);
        #3;
        rst = 1'b1;
        track_visible = 1'b0;
        #1;
        chk("async_reset_outputs", {countdown, controls_en, timer_start, timer_stop,
                                    lap_count, timed_out, race_done}, 0);
        step(2);
        rst = 1'b0;
        ts0 = ts_cnt;
        for (int j = 0; j < 2 * FPS * CS; j++) rand_frame();
        chk("post_reset_idle_cd", countdown, 0);
        chk("post_reset_no_start", ts_cnt, ts0);

        for (int r = 0; r < 12; r++) begin
            kind = (r < 4) ? r : $urandom_range(0, 3);
            start_race();
            run_countdown(kind == 2, ab);
            if (!ab) run_racing(kind);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
